// File: rtl/cache_rd_arbiter.sv
// Round-robin read arbiter: two requesters (inst, data) share one AXI read
// channel, with a single outstanding transaction and write-hazard blocking.
module cache_rd_arbiter #(
  parameter int         LINE_BEATS = 4,
  parameter logic [2:0] LINE_TYPE  = 3'b100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_rd_req,
  input  logic [2:0]  inst_rd_type,
  input  logic [31:0] inst_rd_addr,
  output logic        inst_rd_rdy,
  output logic        inst_ret_valid,
  output logic        inst_ret_last,
  output logic [31:0] inst_rdata,
  input  logic        data_rd_req,
  input  logic [2:0]  data_rd_type,
  input  logic [31:0] data_rd_addr,
  output logic        data_rd_rdy,
  output logic        data_ret_valid,
  output logic        data_ret_last,
  output logic [31:0] data_rdata,
  input  logic        wr_pend,
  input  logic [31:0] wr_pend_addr,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {IDLE, AR, R} state_e;

  state_e      state_q, state_d;
  logic        last_q;            // 0: inst granted last, 1: data granted last
  logic        id_q;
  logic [31:0] addr_q;
  logic [2:0]  type_q;
  logic        inst_elig, data_elig, gnt_inst, gnt_data, beat;
  logic        inst_rv_q, data_rv_q, inst_rl_q, data_rl_q;
  logic [31:0] inst_rd_q, data_rd_q;
  logic        unused_wr_lo;

  // A read hitting the 16-byte block of a pending write must wait for it.
  assign inst_elig = inst_rd_req & ~(wr_pend & (inst_rd_addr[31:4] == wr_pend_addr[31:4]));
  assign data_elig = data_rd_req & ~(wr_pend & (data_rd_addr[31:4] == wr_pend_addr[31:4]));
  assign unused_wr_lo = ^wr_pend_addr[3:0];

  always_comb begin
    state_d  = state_q;
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    case (state_q)
      IDLE: begin
        if (inst_elig && data_elig) begin
          gnt_inst = last_q;
          gnt_data = ~last_q;
        end else begin
          gnt_inst = inst_elig;
          gnt_data = data_elig;
        end
        if (gnt_inst || gnt_data) state_d = AR;
      end
      AR:      if (arready) state_d = R;
      R:       if (rvalid && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      id_q    <= 1'b0;
      addr_q  <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      if (gnt_inst || gnt_data) begin
        last_q <= gnt_data;
        id_q   <= gnt_data;
        addr_q <= gnt_data ? data_rd_addr : inst_rd_addr;
        type_q <= gnt_data ? data_rd_type : inst_rd_type;
      end
    end
  end

  assign inst_rd_rdy = gnt_inst;
  assign data_rd_rdy = gnt_data;

  // AR payload is forced to zero outside the AR state.
  assign arvalid = (state_q == AR);
  assign araddr  = arvalid ? addr_q : '0;
  assign arid    = arvalid ? {3'b000, id_q} : '0;
  assign arburst = arvalid ? 2'b01 : 2'b00;
  assign arlen   = (arvalid && type_q == LINE_TYPE) ? 8'(LINE_BEATS - 1) : 8'd0;
  always_comb begin
    arsize = 3'd0;
    if (arvalid) begin
      case (type_q)
        3'd0:    arsize = 3'd0;
        3'd1:    arsize = 3'd1;
        default: arsize = 3'd2;
      endcase
    end
  end

  assign rready = (state_q == R);
  assign beat   = rready & rvalid;

  always_ff @(posedge clk) begin
    if (reset) begin
      inst_rv_q <= 1'b0;
      data_rv_q <= 1'b0;
      inst_rl_q <= 1'b0;
      data_rl_q <= 1'b0;
      inst_rd_q <= '0;
      data_rd_q <= '0;
    end else begin
      inst_rv_q <= beat & ~id_q;
      data_rv_q <= beat & id_q;
      inst_rl_q <= beat & ~id_q & rlast;
      data_rl_q <= beat & id_q & rlast;
      if (beat && !id_q) inst_rd_q <= rdata;
      if (beat &&  id_q) data_rd_q <= rdata;
    end
  end

  assign inst_ret_valid = inst_rv_q;
  assign data_ret_valid = data_rv_q;
  assign inst_ret_last  = inst_rl_q;
  assign data_ret_last  = data_rl_q;
  assign inst_rdata     = inst_rd_q;
  assign data_rdata     = data_rd_q;

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// Random-stimulus bench: the bench acts as requesters and AXI slave and
// predicts each transaction from the arbitration and AXI mapping rules.
module tb_cache_rd_arbiter;

  localparam int         LINE_BEATS = 4;
  localparam logic [2:0] LINE_TYPE  = 3'b100;
  localparam int         NCYC       = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_rd_req, data_rd_req;
  logic [2:0]  inst_rd_type, data_rd_type;
  logic [31:0] inst_rd_addr, data_rd_addr;
  logic        inst_rd_rdy, data_rd_rdy;
  logic        inst_ret_valid, data_ret_valid, inst_ret_last, data_ret_last;
  logic [31:0] inst_rdata, data_rdata;
  logic        wr_pend;
  logic [31:0] wr_pend_addr;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic        rlast, rvalid, rready;

  cache_rd_arbiter #(.LINE_BEATS(LINE_BEATS), .LINE_TYPE(LINE_TYPE)) dut (
    .clk(clk), .reset(reset),
    .inst_rd_req(inst_rd_req), .inst_rd_type(inst_rd_type), .inst_rd_addr(inst_rd_addr),
    .inst_rd_rdy(inst_rd_rdy), .inst_ret_valid(inst_ret_valid), .inst_ret_last(inst_ret_last),
    .inst_rdata(inst_rdata),
    .data_rd_req(data_rd_req), .data_rd_type(data_rd_type), .data_rd_addr(data_rd_addr),
    .data_rd_rdy(data_rd_rdy), .data_ret_valid(data_ret_valid), .data_ret_last(data_ret_last),
    .data_rdata(data_rdata),
    .wr_pend(wr_pend), .wr_pend_addr(wr_pend_addr),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level reference state
  bit          busy, addr_sent, last_data;
  bit          cap_id;
  logic [31:0] cap_addr;
  logic [2:0]  cap_type;
  int          beat_idx;
  bit [1:0]    exp_rv, exp_rl;
  logic [31:0] exp_rd [2];
  int          grants_inst, grants_data, resets_mid;

  function automatic int nbeats(input logic [2:0] t);
    return (t == LINE_TYPE) ? LINE_BEATS : 1;
  endfunction

  function automatic logic [2:0] size_of(input logic [2:0] t);
    return (t == 3'd0) ? 3'd0 : (t == 3'd1) ? 3'd1 : 3'd2;
  endfunction

  function automatic bit blocked(input logic [31:0] a);
    return wr_pend && (a[31:4] == wr_pend_addr[31:4]);
  endfunction

  function automatic logic [2:0] rand_type();
    logic [2:0] tbl [5];
    tbl = '{3'd0, 3'd1, 3'd2, 3'd3, LINE_TYPE};
    return tbl[$urandom_range(0, 4)];
  endfunction

  function automatic logic [31:0] rand_addr();
    return {26'h0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
  endfunction

  task automatic model_reset();
    busy = 0; addr_sent = 0; last_data = 0; beat_idx = 0;
    exp_rv = '0; exp_rl = '0; exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  initial begin
    bit ie, de, wi, wd;
    bit [1:0] nrv, nrl;
    grants_inst = 0; grants_data = 0; resets_mid = 0;
    reset = 1'b1;
    inst_rd_req = 0; data_rd_req = 0; inst_rd_type = 0; data_rd_type = 0;
    inst_rd_addr = 0; data_rd_addr = 0; wr_pend = 0; wr_pend_addr = 0;
    arready = 0; rdata = 0; rlast = 0; rvalid = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arid_len_size_burst", {arid, arlen, arsize, arburst}, 32'd0);
    chk("rst_ret", {inst_ret_valid, data_ret_valid, inst_ret_last, data_ret_last}, 32'd0);
    chk("rst_rdata", inst_rdata | data_rdata, 32'd0);

    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      reset        = ($urandom_range(0, 199) == 0);
      inst_rd_req  = ($urandom_range(0, 2) != 0);
      data_rd_req  = ($urandom_range(0, 2) != 0);
      inst_rd_type = rand_type();
      data_rd_type = rand_type();
      inst_rd_addr = rand_addr();
      data_rd_addr = rand_addr();
      wr_pend      = $urandom_range(0, 1);
      wr_pend_addr = rand_addr();
      arready      = ($urandom_range(0, 2) == 0);
      rvalid       = busy && addr_sent && ($urandom_range(0, 3) != 0);
      rlast        = rvalid && (beat_idx == nbeats(cap_type) - 1);
      rdata        = $urandom;

      @(negedge clk);
      ie = inst_rd_req && !blocked(inst_rd_addr);
      de = data_rd_req && !blocked(data_rd_addr);
      wi = 0; wd = 0;
      if (!busy) begin
        if (ie && de) begin wd = !last_data; wi = last_data; end
        else begin wi = ie; wd = de; end
      end
      if (!reset) begin
        chk("inst_rd_rdy", 32'(inst_rd_rdy), 32'(wi));
        chk("data_rd_rdy", 32'(data_rd_rdy), 32'(wd));
      end
      chk("arvalid", 32'(arvalid), 32'(busy && !addr_sent));
      chk("rready", 32'(rready), 32'(busy && addr_sent));
      if (busy && !addr_sent) begin
        chk("araddr", araddr, cap_addr);
        chk("arid", 32'(arid), 32'(cap_id));
        chk("arburst", 32'(arburst), 32'd1);
        chk("arsize", 32'(arsize), 32'(size_of(cap_type)));
        chk("arlen", 32'(arlen), 32'(nbeats(cap_type) - 1));
      end
      chk("inst_ret_valid", 32'(inst_ret_valid), 32'(exp_rv[0]));
      chk("data_ret_valid", 32'(data_ret_valid), 32'(exp_rv[1]));
      chk("inst_rdata", inst_rdata, exp_rd[0]);
      chk("data_rdata", data_rdata, exp_rd[1]);
      if (exp_rv[0]) chk("inst_ret_last", 32'(inst_ret_last), 32'(exp_rl[0]));
      if (exp_rv[1]) chk("data_ret_last", 32'(data_ret_last), 32'(exp_rl[1]));

      if (reset) begin
        if (busy) resets_mid++;
        model_reset();
      end else begin
        nrv = '0; nrl = '0;
        if (busy && addr_sent && rvalid) begin
          nrv[cap_id] = 1'b1;
          nrl[cap_id] = rlast;
          exp_rd[cap_id] = rdata;
          beat_idx++;
          if (rlast) busy = 0;
        end else if (busy && !addr_sent) begin
          if (arready) addr_sent = 1;
        end else if (!busy && (wi || wd)) begin
          busy      = 1;
          addr_sent = 0;
          beat_idx  = 0;
          cap_id    = wd;
          cap_addr  = wd ? data_rd_addr : inst_rd_addr;
          cap_type  = wd ? data_rd_type : inst_rd_type;
          last_data = wd;
          if (wd) grants_data++; else grants_inst++;
        end
        exp_rv = nrv;
        exp_rl = nrl;
      end
    end

    @(posedge clk);
    #1 reset = 1'b0;
    $display("[TB] grants inst=%0d data=%0d, mid-transaction resets=%0d",
             grants_inst, grants_data, resets_mid);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_rd_arbiter.md
CACHE_RD_ARBITER -- requirements
Module: cache_rd_arbiter

Interface
REQ-001 Parameter LINE_BEATS, default 4: beats per cache-line burst; legal values 1..16.
REQ-002 Parameter LINE_TYPE, default 3'b100: rd_type code for a cache-line read.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 {inst,data}_rd_req  in  1  read request from the requester; the inst and data ports are identical.
REQ-006 {inst,data}_rd_type  in  3  read size: 0 byte, 1 half, 2 word, LINE_TYPE line.
REQ-007 {inst,data}_rd_addr  in  32  read byte address.
REQ-008 {inst,data}_rd_rdy  out  1  request accepted this cycle; combinational.
REQ-009 {inst,data}_ret_valid  out  1  returned beat valid; registered.
REQ-010 {inst,data}_ret_last  out  1  final beat of the transaction; registered.
REQ-011 {inst,data}_rdata  out  32  returned beat data; registered.
REQ-012 wr_pend  in  1  write path holds an unfinished write.
REQ-013 wr_pend_addr  in  32  address of that pending write.
REQ-014 arid  out  4  requester ID: 0 inst, 1 data.
REQ-015 araddr  out  32  AXI AR address.
REQ-016 arlen  out  8  AXI AR burst length.
REQ-017 arsize  out  3  AXI AR beat size.
REQ-018 arburst  out  2  AXI AR burst type.
REQ-019 arvalid  out  1  AXI AR valid.
REQ-020 arready  in  1  AXI AR ready.
REQ-021 rdata  in  32  AXI R data.
REQ-022 rlast  in  1  AXI R last.
REQ-023 rvalid  in  1  AXI R valid.
REQ-024 rready  out  1  AXI R ready.

Function
REQ-025 The FSM SHALL have exactly three states, IDLE, AR and R, with only one AXI read outstanding at any time.
REQ-026 A requester SHALL be eligible when rd_req=1 and NOT (wr_pend and rd_addr[31:4]==wr_pend_addr[31:4]); a blocked requester never blocks the other requester.
REQ-027 In IDLE, a single eligible requester SHALL be granted; when both are eligible, grant SHALL go to the one not granted last (round-robin).
REQ-028 The grant SHALL raise that requester's rd_rdy in the same cycle, combinationally.
REQ-029 On grant, the block SHALL capture addr, type and ID, update last-grant, and move to AR.
REQ-030 rd_rdy SHALL be 0 outside IDLE and for any non-granted requester.
REQ-031 In AR: arvalid=1; araddr, arid and arburst=2'b01 (INCR) driven from captured values.
REQ-032 In AR: arsize = 0 for byte, 1 for half, 2 for word, line or unknown type.
REQ-033 In AR: arlen = LINE_BEATS-1 for a line read, 0 otherwise.
REQ-034 AR payload SHALL stay stable until arready; on arvalid&arready the FSM moves to R.
REQ-035 In R: rready=1 and arvalid=0.
REQ-036 In R, each rvalid beat SHALL appear one cycle later on the granted requester's ret_valid, rdata and ret_last (ret_last = rlast).
REQ-037 Beats SHALL be routed by the captured grant; rid is not used for routing.
REQ-038 The non-granted requester's ret_valid SHALL stay 0.
REQ-039 On rvalid&rlast the FSM SHALL return to IDLE, so a new grant is possible in the cycle after the last beat.
REQ-040 ret_valid SHALL be a one-cycle pulse per beat; with no rvalid the next cycle, ret_valid=0 and rdata holds its value.
REQ-041 Minimum latency SHALL be: req accepted cycle 0, arvalid cycle 1, rready cycle 2, first ret_valid one cycle after the first beat.

Reset
REQ-042 On reset: state IDLE, last-grant=inst (data wins the first tie), all outputs 0.
REQ-043 Reset mid-transaction SHALL abandon the transaction; no ret_valid follows on either port.

Verification
REQ-044 Both requesters request at once after reset, data line read addr 0x100 -> data_rd_rdy=1 in cycle 0; cycle 1 arid=1, arlen=3, arsize=2; 4 beats returned with the last flagged by data_ret_last.
REQ-045 Both requesters hold requests across three transactions -> grants alternate data, inst, data.
REQ-046 data read addr 0x208 with wr_pend=1, wr_pend_addr=0x200, and an inst request present -> inst granted; data granted only after wr_pend=0.
REQ-047 arready held low for 5 cycles -> arvalid, araddr and arlen stable for all 5 cycles; rready=0 throughout.
REQ-048 inst byte read addr 0x3 -> arsize=0, arlen=0; single beat returned with inst_ret_last=1.
REQ-049 reset pulsed after the 2nd of 4 beats -> no further ret_valid; a new request is granted immediately after reset.
